// File: rtl/prores_block_loader_if.sv
// Pixel-stream handshake between the macroblock source and prores_block_loader.
// The source drives valid/data; the loader returns ready.
interface prores_block_loader_if;
    logic        valid;
    logic [31:0] data;
    logic        ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/prores_block_loader.sv
// Scatters one raster-order 16x16 luma macroblock into a block-major 8x8 block memory.
// Optional build macro PRORES_BLOCK_LOADER_LEVEL_SHIFT_EN stores (sample[9:0] - 512) instead of raw beats.
module prores_block_loader #(
    parameter int MAX_BLOCK_NUM = 32,
    parameter int MAX_PIXEL_NUM = 64
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic [$clog2(MAX_BLOCK_NUM)-1:0] base_block_i,
    prores_block_loader_if.slave             pix_if,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [31:0]                      blocks_written_o,
    output logic [31:0]                      output_data_o [MAX_BLOCK_NUM*MAX_PIXEL_NUM]
);

    localparam int BW    = $clog2(MAX_BLOCK_NUM);
    localparam int WORDS = MAX_BLOCK_NUM * MAX_PIXEL_NUM;
    localparam int AW    = $clog2(WORDS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [7:0]    p_q, p_d;
    logic [BW-1:0] base_q, base_d;
    logic          ready_q;
    logic          done_q, done_d;
    logic [31:0]   bw_q, bw_d;
    logic [31:0]   mem_q [WORDS];

    logic          accept_s;
    logic          last_s;
    logic [AW-1:0] wr_addr_s;
    logic [31:0]   wr_data_s;

    // Quadrant of the macroblock picks one of four consecutive slots; slots wrap past the last one.
    function automatic logic [AW-1:0] pixel_addr(input logic [BW-1:0] base, input logic [7:0] p);
        logic [BW:0]   sum;
        logic [BW-1:0] blk;
        sum = {1'b0, base} + {{(BW-1){1'b0}}, p[7], 1'b0} + {{BW{1'b0}}, p[3]};
        if (sum >= (BW+1)'(MAX_BLOCK_NUM)) begin
            blk = BW'(sum - (BW+1)'(MAX_BLOCK_NUM));
        end else begin
            blk = sum[BW-1:0];
        end
        pixel_addr = AW'(blk) * AW'(MAX_PIXEL_NUM) + AW'({p[6:4], p[2:0]});
    endfunction

`ifdef PRORES_BLOCK_LOADER_LEVEL_SHIFT_EN
    function automatic logic [31:0] level_shift(input logic [9:0] sample);
        level_shift = {22'd0, sample} - 32'd512;
    endfunction
`endif

    // Write-port decode for the current beat.
    always_comb begin
        accept_s  = pix_if.valid && ready_q;
        last_s    = (p_q == 8'd255);
        wr_addr_s = pixel_addr(base_q, p_q);
`ifdef PRORES_BLOCK_LOADER_LEVEL_SHIFT_EN
        wr_data_s = level_shift(pix_if.data[9:0]);
`else
        wr_data_s = pix_if.data;
`endif
    end

    // FSM next-state, pixel index and block counter.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        base_d  = base_q;
        done_d  = 1'b0;
        bw_d    = bw_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    p_d     = 8'd0;
                    base_d  = base_block_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    p_d = p_q + 8'd1;
                    if (last_s) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        bw_d    = bw_q + 32'd4;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    p_d = p_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; ready is registered from the next state so it never follows in_valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            p_q     <= 8'd0;
            base_q  <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            bw_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            base_q  <= base_d;
            ready_q <= (state_d == ST_LOAD);
            done_q  <= done_d;
            bw_q    <= bw_d;
        end
    end

    // Block memory; cleared by reset so an aborted load leaves nothing behind.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (accept_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    assign pix_if.ready     = ready_q;
    assign busy_o           = ready_q;
    assign done_o           = done_q;
    assign blocks_written_o = bw_q;
    assign output_data_o    = mem_q;

endmodule

// File: tb/tb_prores_block_loader.sv
// Randomized bench for prores_block_loader against a coordinate-level model of the block memory.
// Expectations follow the PRORES_BLOCK_LOADER_LEVEL_SHIFT_EN build setting.
module tb_prores_block_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  base_block;
    logic        busy;
    logic        done;
    logic [31:0] bw;
    logic [31:0] mem_w [2048];

    prores_block_loader_if pix_if();

    prores_block_loader dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .base_block_i     (base_block),
        .pix_if           (pix_if),
        .busy_o           (busy),
        .done_o           (done),
        .blocks_written_o (bw),
        .output_data_o    (mem_w)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ref_mem  [2048];
    logic [31:0] snap_mem [2048];
    logic [31:0] exp_bw;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pixel (x,y) of the macroblock lands in quadrant block (y/8, x/8) at row y%8, column x%8.
    function automatic int model_addr(input int base, input int p);
        int x;
        int y;
        int blk;
        x   = p % 16;
        y   = p / 16;
        blk = (base + 2 * (y / 8) + (x / 8)) % 32;
        return blk * 64 + (y % 8) * 8 + (x % 8);
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] d);
`ifdef PRORES_BLOCK_LOADER_LEVEL_SHIFT_EN
        longint v;
        v = longint'(d % 32'd1024) - 64'sd512;
        return v[31:0];
`else
        return d;
`endif
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2048; i++) ref_mem[i] = 32'd0;
        exp_bw = 32'd0;
    endtask

    task automatic compare_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 2048; i++) if (mem_w[i] !== ref_mem[i]) bad++;
        check_eq(tag, bad, 0);
    endtask

    task automatic check_idle_reset(input string tag);
        check_eq({tag, "_ready"}, pix_if.ready, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_bw"}, bw, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; pix_if.valid = 1'b0; pix_if.data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    // mode 0: data = p, 1: random, 2: special samples at p=0..2; abort_at >= 0 resets after that many accepts.
    task automatic run_load(input int base, input int bubble_pct, input int mode,
                            input int abort_at, input bit start_noise);
        int          p   = 0;
        int          cyc = 0;
        logic [31:0] d;
        bit          v;
        @(posedge clk); #1;
        start = 1'b1; base_block = base[4:0];
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("ready_after_start", pix_if.ready, 1'b1);
        check_eq("busy_after_start", busy, 1'b1);
        while (p < 256 && cyc < 4000) begin
            v = ($urandom_range(99) >= bubble_pct);
            case (mode)
                0:       d = p;
                2:       d = (p == 0) ? 32'd0 : (p == 1) ? 32'd1023 : (p == 2) ? 32'hFFFF0200 : $urandom;
                default: d = $urandom;
            endcase
            pix_if.valid = v;
            pix_if.data  = d;
            start        = start_noise && ($urandom_range(7) == 0);
            base_block   = 5'($urandom);
            @(posedge clk); #1;
            cyc++;
            if (v) begin
                ref_mem[model_addr(base, p)] = model_store(d);
                p++;
            end
            if (p < 256) check_eq("no_early_done", done, 1'b0);
            if (abort_at >= 0 && p == abort_at) begin
                rst = 1'b1; pix_if.valid = 1'b0; start = 1'b0;
                repeat (2) begin
                    @(posedge clk); #1;
                    check_eq("abort_no_done", done, 1'b0);
                end
                rst = 1'b0;
                clear_model();
                return;
            end
        end
        pix_if.valid = 1'b0;
        start        = 1'b0;
        if (p < 256) begin
            check_eq("load_timeout", p, 256);
            return;
        end
        exp_bw += 32'd4;
        check_eq("done_pulse", done, 1'b1);
        check_eq("ready_after_done", pix_if.ready, 1'b0);
        check_eq("busy_after_done", busy, 1'b0);
        check_eq("blocks_written", bw, exp_bw);
        if (bubble_pct == 0) check_eq("done_latency", cyc, 256);
        @(posedge clk); #1;
        check_eq("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int b;
        int diff;
        rst = 1'b1; start = 1'b0; base_block = 5'd0;
        pix_if.valid = 1'b0; pix_if.data = 32'd0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_reset("reset");
        check_eq("reset_mem0", mem_w[0], 32'd0);
        check_eq("reset_mem2047", mem_w[2047], 32'd0);

        // Straight macroblock at base 0, data = pixel index.
        run_load(0, 0, 0, -1, 1'b0);
        check_eq("a_mem8", mem_w[8], model_store(32'd16));
        check_eq("a_mem64", mem_w[64], model_store(32'd8));
        check_eq("a_mem128", mem_w[128], model_store(32'd128));
        check_eq("a_mem255", mem_w[255], model_store(32'd255));
        compare_mem("a_mem_all");
        for (int i = 0; i < 2048; i++) snap_mem[i] = ref_mem[i];

        // Slot wrap from base 31.
        run_load(31, 0, 0, -1, 1'b0);
        check_eq("wrap_mem1984", mem_w[1984], model_store(32'd0));
        check_eq("wrap_mem0", mem_w[0], model_store(32'd8));
        check_eq("wrap_mem255", mem_w[255], model_store(32'd255));
        compare_mem("wrap_mem_all");

        // Backpressure plus spurious starts must rebuild the straight-run image.
        do_reset();
        check_idle_reset("srst");
        run_load(0, 50, 0, -1, 1'b1);
        diff = 0;
        for (int i = 0; i < 2048; i++) if (mem_w[i] !== snap_mem[i]) diff++;
        check_eq("bp_vs_straight", diff, 0);

        // Abort after 100 accepts, then a full load.
        run_load(int'($urandom_range(31)), 20, 1, 100, 1'b0);
        check_idle_reset("abort");
        compare_mem("abort_mem_clear");
        run_load(int'($urandom_range(31)), 30, 1, -1, 1'b1);
        compare_mem("post_abort_mem");

        for (int k = 0; k < 4; k++) begin
            run_load(int'($urandom_range(31)), int'($urandom_range(70)), 1, -1, 1'b1);
            compare_mem("rand_mem");
        end

        // Sample formatting corner values.
        b = int'($urandom_range(31));
        run_load(b, 0, 2, -1, 1'b0);
`ifdef PRORES_BLOCK_LOADER_LEVEL_SHIFT_EN
        check_eq("ls_zero", mem_w[model_addr(b, 0)], 32'hFFFFFE00);
        check_eq("ls_max", mem_w[model_addr(b, 1)], 32'h000001FF);
        check_eq("ls_hibits", mem_w[model_addr(b, 2)], 32'h00000000);
`else
        check_eq("raw_zero", mem_w[model_addr(b, 0)], 32'h00000000);
        check_eq("raw_max", mem_w[model_addr(b, 1)], 32'h000003FF);
        check_eq("raw_hibits", mem_w[model_addr(b, 2)], 32'hFFFF0200);
`endif
        compare_mem("special_mem_all");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
